// File: rtl/wb_pkg.sv
// Shared types and defaults for the L1 write-back buffer (buffer_escrita).
// Build option WB_COALESCE_EN merges writes that hit an already buffered address.
package wb_pkg;

    localparam int WB_DEPTH  = 4;
    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 3;
    localparam int WB_PTR_W  = $clog2(WB_DEPTH);
    localparam int WB_CNT_W  = WB_PTR_W + 1;

    typedef struct packed {
        logic                 valid;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/buffer_escrita_cam.sv
// Associative lookup over the buffer entries.
// Scans from head toward tail so the last match found is the youngest one.
module buffer_escrita_cam
    import wb_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int ADDR_W = WB_ADDR_W,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]             valid,
    input  logic [DEPTH-1:0][ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0]            key,
    input  logic [PTR_W-1:0]             head,
    output logic                         hit,
    output logic [PTR_W-1:0]             idx
);

    logic [PTR_W-1:0] pos;

    always_comb begin
        hit = 1'b0;
        idx = head;
        pos = '0;
        for (int k = 0; k < DEPTH; k++) begin
            pos = head + PTR_W'(k);
            if (valid[pos] && (addr[pos] == key)) begin
                hit = 1'b1;
                idx = pos;
            end
        end
    end

endmodule

// File: rtl/buffer_escrita.sv
// Write-back FIFO between the L1 memory port and the single-port RAM.
// Build option WB_COALESCE_EN merges writes that hit an already buffered address.
module buffer_escrita
    import wb_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_req,
    input  logic [ADDR_W-1:0]      wr_end,
    input  logic [DATA_W-1:0]      wr_dado,
    input  logic                   rd_req,
    input  logic [ADDR_W-1:0]      rd_end,
    output logic                   full,
    output logic                   rd_hit,
    output logic [DATA_W-1:0]      rd_dado,
    output logic [ADDR_W-1:0]      ram_endereco,
    output logic [DATA_W-1:0]      ram_dado,
    output logic                   ram_wren,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic [DEPTH-1:0]             valid_v;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_v;

    logic             drain;
    logic             push;
    logic             drop;
    logic             coal;
    logic [PTR_W-1:0] coal_idx;
    logic             fwd_hit;
    logic [PTR_W-1:0] fwd_idx;

    always_comb begin
        valid_v = '0;
        addr_v  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_v[i] = mem[i].valid;
            addr_v[i]  = mem[i].addr;
        end
    end

    // Reset gates the drain so nothing reaches RAM in the reset cycle.
    assign drain = (cnt != '0) && !rd_req && !reset;
    assign full  = (cnt == FULL_CNT);

    buffer_escrita_cam #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fwd_cam (
        .valid (valid_v),
        .addr  (addr_v),
        .key   (rd_end),
        .head  (head),
        .hit   (fwd_hit),
        .idx   (fwd_idx)
    );

`ifdef WB_COALESCE_EN
    logic             wr_hit;
    logic [PTR_W-1:0] wr_idx;

    buffer_escrita_cam #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_wr_cam (
        .valid (valid_v),
        .addr  (addr_v),
        .key   (wr_end),
        .head  (head),
        .hit   (wr_hit),
        .idx   (wr_idx)
    );

    // A head being written out this cycle would lose the merge; allocate instead.
    assign coal     = wr_req && wr_hit && !((wr_idx == head) && drain);
    assign coal_idx = wr_idx;
`else
    assign coal     = 1'b0;
    assign coal_idx = '0;
`endif

    assign push = wr_req && !coal && !full;
    assign drop = wr_req && !coal && full;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
        end else begin
            if (drain) begin
                mem[head].valid <= 1'b0;
                head            <= head + PTR_W'(1);
            end
            if (push) begin
                mem[tail] <= '{valid: 1'b1, addr: wr_end, data: wr_dado};
                tail      <= tail + PTR_W'(1);
            end
            if (coal) begin
                mem[coal_idx].data <= wr_dado;
            end
            if (push && !drain) begin
                cnt <= cnt + CNT_W'(1);
            end else if (drain && !push) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

    assign rd_hit  = fwd_hit;
    assign rd_dado = fwd_hit ? mem[fwd_idx].data : '0;

    assign ram_wren     = drain;
    assign ram_endereco = drain ? mem[head].addr : rd_end;
    assign ram_dado     = drain ? mem[head].data : '0;

    assign overflow = ovf;
    assign count    = cnt;

endmodule

// File: tb/tb_buffer_escrita.sv
// Scenario bench for buffer_escrita with a RAM-write scoreboard.
// Build with +define+WB_COALESCE_EN to exercise the merging variant.
module tb_buffer_escrita;

    localparam int DEPTH = 4;

    logic       clock;
    logic       reset;
    logic       wr_req;
    logic [4:0] wr_end;
    logic [2:0] wr_dado;
    logic       rd_req;
    logic [4:0] rd_end;
    logic       full;
    logic       rd_hit;
    logic [2:0] rd_dado;
    logic [4:0] ram_endereco;
    logic [2:0] ram_dado;
    logic       ram_wren;
    logic       overflow;
    logic [2:0] count;

    buffer_escrita dut (
        .clock        (clock),
        .reset        (reset),
        .wr_req       (wr_req),
        .wr_end       (wr_end),
        .wr_dado      (wr_dado),
        .rd_req       (rd_req),
        .rd_end       (rd_end),
        .full         (full),
        .rd_hit       (rd_hit),
        .rd_dado      (rd_dado),
        .ram_endereco (ram_endereco),
        .ram_dado     (ram_dado),
        .ram_wren     (ram_wren),
        .overflow     (overflow),
        .count        (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [4:0] a;
        logic [2:0] d;
    } ent_t;

    ent_t mq[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   armed = 0;

    // Scoreboard: accepted writes queue up here and are retired by RAM writes.
    always @(negedge clock) begin
        int cj;
        int occ;
        bit exp_drain;
        if (armed) begin
            n_vec++;
            if (reset) begin
                if (ram_wren !== 1'b0) begin
                    n_bad++;
                    $display("FAIL sb_reset_wren got %b exp 0", ram_wren);
                end
                mq.delete();
            end else begin
                occ = mq.size();
                exp_drain = (occ > 0) && !rd_req;
                if (ram_wren !== exp_drain) begin
                    n_bad++;
                    $display("FAIL sb_wren got %b exp %b t=%0t", ram_wren, exp_drain, $time);
                end else if (exp_drain) begin
                    if (ram_endereco !== mq[0].a || ram_dado !== mq[0].d) begin
                        n_bad++;
                        $display("FAIL sb_ramwr got %h/%h exp %h/%h", ram_endereco, ram_dado, mq[0].a, mq[0].d);
                    end
                end else if (ram_endereco !== rd_end) begin
                    n_bad++;
                    $display("FAIL sb_addr_mux got %h exp %h", ram_endereco, rd_end);
                end
                cj = -1;
`ifdef WB_COALESCE_EN
                for (int j = 0; j < occ; j++) begin
                    if (mq[j].a == wr_end) cj = j;
                end
                if (cj == 0 && exp_drain) cj = -1;
`endif
                if (exp_drain) void'(mq.pop_front());
                if (wr_req) begin
                    if (cj >= 0) begin
                        mq[cj - (exp_drain ? 1 : 0)].d = wr_dado;
                    end else if (occ < DEPTH) begin
                        mq.push_back('{wr_end, wr_dado});
                    end
                end
            end
        end
    end

    task automatic tick(input logic w, input logic [4:0] wa, input logic [2:0] wd,
                        input logic r, input logic [4:0] ra);
        @(posedge clock);
        #1;
        wr_req  = w;
        wr_end  = wa;
        wr_dado = wd;
        rd_req  = r;
        rd_end  = ra;
    endtask

    task automatic pulse_reset;
        @(posedge clock);
        #1;
        reset = 1'b1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        rd_end = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        armed = 1;
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        #1;
        n_vec++;
        if (count !== 3'd0 || full !== 1'b0 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state got cnt=%0d full=%b ovf=%b exp 0/0/0", count, full, overflow);
        end
        n_vec++;
        if (rd_hit !== 1'b0 || rd_dado !== 3'd0 || ram_wren !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outs got hit=%b dado=%0d wren=%b exp 0/0/0", rd_hit, rd_dado, ram_wren);
        end
        n_vec++;
        if (ram_endereco !== 5'h00 || ram_dado !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_ram got %h/%h exp 00/0", ram_endereco, ram_dado);
        end
        reset = 1'b0;
    endtask

    task automatic test_single;
        tick(1, 5'h03, 3'h5, 0, 0);
        tick(0, 0, 0, 0, 0);
        #1;
        n_vec++;
        if (count !== 3'd1 || ram_wren !== 1'b1 || ram_endereco !== 5'h03 || ram_dado !== 3'h5) begin
            n_bad++;
            $display("FAIL single_drain got cnt=%0d wren=%b %h/%h exp 1 1 03/5", count, ram_wren, ram_endereco, ram_dado);
        end
        tick(0, 0, 0, 0, 0);
        #1;
        n_vec++;
        if (count !== 3'd0 || ram_wren !== 1'b0) begin
            n_bad++;
            $display("FAIL single_empty got cnt=%0d wren=%b exp 0 0", count, ram_wren);
        end
    endtask

    task automatic test_fill_overflow;
        logic [4:0] a;
        for (int i = 0; i < 4; i++) begin
            a = 5'h10 + 5'(i);
            tick(1, a, 3'(i + 1), 1, 0);
        end
        tick(1, 5'h14, 3'h6, 1, 0);
        #1;
        n_vec++;
        if (count !== 3'd4 || full !== 1'b1 || ram_wren !== 1'b0) begin
            n_bad++;
            $display("FAIL fill_full got cnt=%0d full=%b wren=%b exp 4 1 0", count, full, ram_wren);
        end
        tick(0, 0, 0, 1, 0);
        #1;
        n_vec++;
        if (overflow !== 1'b1 || count !== 3'd4) begin
            n_bad++;
            $display("FAIL ovf_set got ovf=%b cnt=%0d exp 1 4", overflow, count);
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0, 0);
            #1;
            a = 5'h10 + 5'(i);
            n_vec++;
            if (ram_wren !== 1'b1 || ram_endereco !== a) begin
                n_bad++;
                $display("FAIL fifo_order got wren=%b addr=%h exp 1 %h", ram_wren, ram_endereco, a);
            end
        end
        tick(0, 0, 0, 0, 0);
        #1;
        n_vec++;
        if (count !== 3'd0 || overflow !== 1'b1 || full !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_sticky got cnt=%0d ovf=%b full=%b exp 0 1 0", count, overflow, full);
        end
    endtask

    task automatic test_forward;
        tick(1, 5'h0A, 3'h2, 1, 0);
        tick(0, 0, 0, 1, 5'h0A);
        #1;
        n_vec++;
        if (rd_hit !== 1'b1 || rd_dado !== 3'h2 || ram_wren !== 1'b0 || ram_endereco !== 5'h0A) begin
            n_bad++;
            $display("FAIL fwd_hit got hit=%b dado=%0d wren=%b addr=%h exp 1 2 0 0a", rd_hit, rd_dado, ram_wren, ram_endereco);
        end
        tick(0, 0, 0, 1, 5'h0B);
        #1;
        n_vec++;
        if (rd_hit !== 1'b0 || rd_dado !== 3'h0) begin
            n_bad++;
            $display("FAIL fwd_miss got hit=%b dado=%0d exp 0 0", rd_hit, rd_dado);
        end
        tick(1, 5'h0C, 3'h3, 1, 5'h0C);
        #1;
        n_vec++;
        if (rd_hit !== 1'b0) begin
            n_bad++;
            $display("FAIL fwd_same_cycle got hit=%b exp 0", rd_hit);
        end
        tick(0, 0, 0, 1, 5'h0C);
        #1;
        n_vec++;
        if (rd_hit !== 1'b1 || rd_dado !== 3'h3 || count !== 3'd2) begin
            n_bad++;
            $display("FAIL fwd_next got hit=%b dado=%0d cnt=%0d exp 1 3 2", rd_hit, rd_dado, count);
        end
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0);
        #1;
        n_vec++;
        if (count !== 3'd0) begin
            n_bad++;
            $display("FAIL fwd_drained got cnt=%0d exp 0", count);
        end
    endtask

    task automatic test_coalesce;
        logic [2:0] exp_cnt;
`ifdef WB_COALESCE_EN
        exp_cnt = 3'd1;
`else
        exp_cnt = 3'd2;
`endif
        tick(1, 5'h0A, 3'h2, 1, 0);
        tick(1, 5'h0A, 3'h7, 1, 0);
        tick(0, 0, 0, 1, 5'h0A);
        #1;
        n_vec++;
        if (count !== exp_cnt || rd_hit !== 1'b1 || rd_dado !== 3'h7) begin
            n_bad++;
            $display("FAIL coalesce got cnt=%0d hit=%b dado=%0d exp %0d 1 7", count, rd_hit, rd_dado, exp_cnt);
        end
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0);
        #1;
        n_vec++;
        if (count !== 3'd0) begin
            n_bad++;
            $display("FAIL coalesce_drained got cnt=%0d exp 0", count);
        end
    endtask

    task automatic test_back_to_back;
        tick(1, 5'h01, 3'h1, 1, 0);
        tick(1, 5'h02, 3'h2, 1, 0);
        tick(1, 5'h03, 3'h3, 0, 0);
        #1;
        n_vec++;
        if (count !== 3'd2) begin
            n_bad++;
            $display("FAIL b2b_pre got cnt=%0d exp 2", count);
        end
        tick(1, 5'h01, 3'h4, 0, 0);
        #1;
        n_vec++;
        if (count !== 3'd2 || ram_endereco !== 5'h02) begin
            n_bad++;
            $display("FAIL b2b_push_pop got cnt=%0d addr=%h exp 2 02", count, ram_endereco);
        end
        tick(1, 5'h03, 3'h6, 0, 0);
        #1;
        n_vec++;
        if (count !== 3'd2 || ram_dado !== 3'h3) begin
            n_bad++;
            $display("FAIL b2b_head_merge got cnt=%0d dado=%0d exp 2 3", count, ram_dado);
        end
        tick(0, 0, 0, 0, 0);
        #1;
        n_vec++;
        if (count !== 3'd2) begin
            n_bad++;
            $display("FAIL b2b_alloc got cnt=%0d exp 2", count);
        end
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0);
        #1;
        n_vec++;
        if (count !== 3'd0) begin
            n_bad++;
            $display("FAIL b2b_drained got cnt=%0d exp 0", count);
        end
    endtask

    task automatic test_reset_mid_drain;
        tick(1, 5'h15, 3'h1, 1, 0);
        tick(1, 5'h16, 3'h2, 1, 0);
        tick(1, 5'h17, 3'h3, 1, 0);
        tick(0, 0, 0, 0, 0);
        #1;
        n_vec++;
        if (ram_wren !== 1'b1 || count !== 3'd3) begin
            n_bad++;
            $display("FAIL mid_drain_pre got wren=%b cnt=%0d exp 1 3", ram_wren, count);
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if (ram_wren !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_drain_gate got wren=%b exp 0", ram_wren);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        n_vec++;
        if (count !== 3'd0 || ram_wren !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_drain_post got cnt=%0d wren=%b exp 0 0", count, ram_wren);
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0, 0);
            #1;
            n_vec++;
            if (ram_wren !== 1'b0) begin
                n_bad++;
                $display("FAIL mid_drain_stale got wren=%b exp 0", ram_wren);
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        wr_req  = 1'b0;
        wr_end  = '0;
        wr_dado = '0;
        rd_req  = 1'b0;
        rd_end  = '0;
        test_reset();
        test_single();
        test_fill_overflow();
        pulse_reset();
        test_forward();
        test_coalesce();
        test_back_to_back();
        test_reset_mid_drain();
        tick(0, 0, 0, 0, 0);
        #1;
        n_vec++;
        if (mq.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover got %0d exp 0", mq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "timeout");
    end

endmodule
